// File: rtl/mm_trans_axil_master.sv
// mm_trans_axil_master: replays packed MM records as single AXI-Lite accesses; define MM_RESP_CHK_EN to track non-OKAY responses
module mm_trans_axil_master #(
  parameter int C_S_AXI_ADDR_WDT = 32,
  parameter int C_S_AXI_DATA_WDT = 32,
  parameter int C_S_AXI_STRB_WDT = 4,
  parameter int C_MM_TRANS_WDT   = 80,
  parameter int C_ERR_CNT_WDT    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [C_MM_TRANS_WDT-1:0]   trans_in_data,
  input  logic                        trans_in_valid,
  output logic                        trans_in_ready,
  output logic [C_S_AXI_DATA_WDT-1:0] rd_data,
  output logic                        rd_data_valid,
  input  logic                        rd_data_ready,
  output logic                        eob_pulse,
  output logic                        busy,
  output logic [C_S_AXI_ADDR_WDT-1:0] M_AXI_AWADDR,
  output logic [2:0]                  M_AXI_AWPROT,
  output logic                        M_AXI_AWVALID,
  input  logic                        M_AXI_AWREADY,
  output logic [C_S_AXI_DATA_WDT-1:0] M_AXI_WDATA,
  output logic [C_S_AXI_STRB_WDT-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  input  logic [1:0]                  M_AXI_BRESP,
  input  logic                        M_AXI_BVALID,
  output logic                        M_AXI_BREADY,
  output logic [C_S_AXI_ADDR_WDT-1:0] M_AXI_ARADDR,
  output logic [2:0]                  M_AXI_ARPROT,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [C_S_AXI_DATA_WDT-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic                        err_flag,
  output logic [C_ERR_CNT_WDT-1:0]    err_cnt
);
  localparam int ADDR_LSB = C_S_AXI_DATA_WDT + 8;
  typedef enum logic [2:0] {S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_RD_OUT} state_t;
  state_t                      r_state;
  logic                        r_in_ready, r_eob, r_busy;
  logic [C_S_AXI_ADDR_WDT-1:0] r_awaddr, r_araddr;
  logic [C_S_AXI_DATA_WDT-1:0] r_wdata, r_rd_data;
  logic [C_S_AXI_STRB_WDT-1:0] r_wstrb;
  logic                        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_rd_valid;
  logic [7:0]                  w_dir;
  logic [C_S_AXI_ADDR_WDT-1:0] w_addr;
  logic [C_S_AXI_DATA_WDT-1:0] w_data;
  logic [C_S_AXI_STRB_WDT-1:0] w_strb;
  logic                        w_accept, w_eob, w_unused;
  assign w_dir    = trans_in_data[C_MM_TRANS_WDT-1 -: 8];
  assign w_addr   = trans_in_data[ADDR_LSB +: C_S_AXI_ADDR_WDT];
  assign w_data   = trans_in_data[8 +: C_S_AXI_DATA_WDT];
  assign w_strb   = trans_in_data[C_S_AXI_STRB_WDT-1:0];
  assign w_eob    = ~|trans_in_data;
  assign w_accept = trans_in_valid & r_in_ready;
  assign trans_in_ready = r_in_ready;
  assign eob_pulse      = r_eob;
  assign busy           = r_busy;
  assign rd_data        = r_rd_data;
  assign rd_data_valid  = r_rd_valid;
  assign M_AXI_AWADDR   = r_awaddr;
  assign M_AXI_AWPROT   = 3'b000;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_WDATA    = r_wdata;
  assign M_AXI_WSTRB    = r_wstrb;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_BREADY   = r_bready;
  assign M_AXI_ARADDR   = r_araddr;
  assign M_AXI_ARPROT   = 3'b000;
  assign M_AXI_ARVALID  = r_arvalid;
  assign M_AXI_RREADY   = r_rready;
  // one-transaction-at-a-time sequencer; every output is a register so reset drops VALIDs immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_eob      <= 1'b0;
      r_busy     <= 1'b0;
      r_awaddr   <= '0;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_araddr   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_eob <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept & ~w_eob) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (|w_dir) begin
              r_state   <= S_WR_REQ;
              r_awaddr  <= w_addr;
              r_awvalid <= 1'b1;
              r_wdata   <= w_data;
              r_wstrb   <= w_strb;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_RD_REQ;
              r_araddr  <= w_addr;
              r_arvalid <= 1'b1;
            end
          end else begin
            r_in_ready <= 1'b1;
            r_eob      <= w_accept;
          end
        end
        S_WR_REQ: begin
          if (M_AXI_AWREADY) begin
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
          end
          if (M_AXI_WREADY) begin
            r_wvalid <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
          end
          if ((~r_awvalid | M_AXI_AWREADY) & (~r_wvalid | M_AXI_WREADY)) begin
            r_state  <= S_WR_RESP;
            r_bready <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_state    <= S_IDLE;
            r_bready   <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        S_RD_REQ: begin
          if (M_AXI_ARREADY) begin
            r_state   <= S_RD_RESP;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_RESP: begin
          if (M_AXI_RVALID) begin
            r_state    <= S_RD_OUT;
            r_rready   <= 1'b0;
            r_rd_data  <= M_AXI_RDATA;
            r_rd_valid <= 1'b1;
          end
        end
        S_RD_OUT: begin
          if (rd_data_ready) begin
            r_state    <= S_IDLE;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef MM_RESP_CHK_EN
  logic                     r_err_flag;
  logic [C_ERR_CNT_WDT-1:0] r_err_cnt;
  logic                     w_resp_err;
  assign w_unused   = ^trans_in_data[7:C_S_AXI_STRB_WDT];
  assign w_resp_err = (r_state == S_WR_RESP & M_AXI_BVALID & |M_AXI_BRESP) |
                      (r_state == S_RD_RESP & M_AXI_RVALID & |M_AXI_RRESP);
  assign err_flag   = r_err_flag;
  assign err_cnt    = r_err_cnt;
  // sticky error flag and saturating count of non-OKAY responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_flag <= 1'b0;
      r_err_cnt  <= '0;
    end else if (w_resp_err) begin
      r_err_flag <= 1'b1;
      r_err_cnt  <= &r_err_cnt ? r_err_cnt : r_err_cnt + C_ERR_CNT_WDT'(1);
    end
  end
`else
  assign w_unused = ^{trans_in_data[7:C_S_AXI_STRB_WDT], M_AXI_BRESP, M_AXI_RRESP};
  assign err_flag = 1'b0;
  assign err_cnt  = '0;
`endif
endmodule

// File: tb/tb_mm_trans_axil_master.sv
// tb_mm_trans_axil_master: randomized record replay against a memory reference model and a delay-configurable AXI-Lite slave
module tb_mm_trans_axil_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [79:0] trans_in_data = '0;
  logic        trans_in_valid = 1'b0;
  logic        trans_in_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        rd_data_ready = 1'b0;
  logic        eob_pulse, busy;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;
  logic        err_flag;
  logic [15:0] err_cnt;
  int checks = 0, errors = 0;
  int aw_dly = 1, w_dly = 1, ar_dly = 1, b_wait = 0, r_wait = 0;
  logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  bit aw_fire, w_fire, ar_fire, b_fire, r_fire, aw_done, w_done, ar_done;
  int n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, aw_hi = 0, w_hi = 0, prot_bad = 0;
  logic [31:0] lg_awaddr = '0, lg_wdata = '0, lg_araddr = '0, s_cur;
  logic [3:0]  lg_wstrb = '0;
  logic [31:0] smem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  mm_trans_axil_master dut (
    .clk(clk), .rst(rst),
    .trans_in_data(trans_in_data), .trans_in_valid(trans_in_valid), .trans_in_ready(trans_in_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .eob_pulse(eob_pulse), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .err_flag(err_flag), .err_cnt(err_cnt)
  );

  // Slave: acts on falling edges; a VALID/READY pair seen here completes on the next rising edge.
  // A READY is raised once its VALID has been high for <ch>_dly cycles; BVALID follows one cycle after
  // the AW/W handshakes are seen (registered response) plus b_wait; RVALID follows AR plus r_wait.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0; aw_done = 0; w_done = 0; ar_done = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (b_fire) begin bvalid = 0; bresp = 0; b_fire = 0; end
      else if (aw_done && w_done && !bvalid) begin
        b_cnt++;
        if (b_cnt > b_wait + 1) begin bvalid = 1; bresp = bresp_val; end
      end
      if (bvalid && bready) begin
        b_fire = 1; b_cnt = 0; aw_done = 0; w_done = 0; n_b++;
        s_cur = smem.exists(lg_awaddr) ? smem[lg_awaddr] : 32'h0;
        for (int i = 0; i < 4; i++) if (lg_wstrb[i]) s_cur[8*i +: 8] = lg_wdata[8*i +: 8];
        smem[lg_awaddr] = s_cur;
      end
      if (r_fire) begin rvalid = 0; rdata = 0; rresp = 0; r_fire = 0; end
      else if (ar_done && !rvalid) begin
        r_cnt++;
        if (r_cnt > r_wait) begin
          rvalid = 1; rresp = rresp_val;
          rdata = smem.exists(lg_araddr) ? smem[lg_araddr] : 32'h0;
        end
      end
      if (rvalid && rready) begin r_fire = 1; r_cnt = 0; ar_done = 0; end
      if (awvalid) aw_hi++;
      if (wvalid) w_hi++;
      if (aw_fire) begin awready = 0; aw_fire = 0; aw_cnt = 0; end
      else if (awvalid) begin
        aw_cnt++;
        if (aw_cnt >= aw_dly) begin
          awready = 1; aw_fire = 1; aw_done = 1; lg_awaddr = awaddr; n_aw++;
          if (awprot != 3'b000) prot_bad++;
        end
      end
      if (w_fire) begin wready = 0; w_fire = 0; w_cnt = 0; end
      else if (wvalid) begin
        w_cnt++;
        if (w_cnt >= w_dly) begin wready = 1; w_fire = 1; w_done = 1; lg_wdata = wdata; lg_wstrb = wstrb; n_w++; end
      end
      if (ar_fire) begin arready = 0; ar_fire = 0; ar_cnt = 0; end
      else if (arvalid) begin
        ar_cnt++;
        if (ar_cnt >= ar_dly) begin
          arready = 1; ar_fire = 1; ar_done = 1; lg_araddr = araddr; n_ar++;
          if (arprot != 3'b000) prot_bad++;
        end
      end
    end
  end

  function automatic logic [79:0] mk(input logic [7:0] dir, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    return {dir, a, d, s};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ref_mem[a] = (model_read(a) & ~m) | (d & m);
  endtask

  task automatic push(input logic [79:0] rec, output bit ok);
    int n = 0;
    trans_in_data = rec;
    trans_in_valid = 1'b1;
    while (!trans_in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    trans_in_valid = 1'b0;
    trans_in_data = '0;
    ok = (n < 100);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while ((busy || !trans_in_ready) && n < 200) begin @(negedge clk); n++; end
    ok = (n < 200);
  endtask

  task automatic wait_rd(output bit ok);
    int n = 0;
    while (!rd_data_valid && n < 200) begin @(negedge clk); n++; end
    ok = (n < 200);
  endtask

  task automatic do_write(input logic [7:0] dir, input logic [31:0] a, input logic [31:0] d, input logic [7:0] s, output bit ok);
    bit ok1, ok2;
    push(mk(dir, a, d, s), ok1);
    wait_idle(ok2);
    model_write(a, d, s);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({trans_in_ready, busy, eob_pulse, rd_data_valid, awvalid, wvalid, bready, arvalid, rready, err_flag} !== 10'b0 ||
        {rd_data, awaddr, wdata, wstrb, araddr, awprot, arprot, err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b busy=%b eob=%b rdv=%b awv=%b wv=%b bready=%b arv=%b rready=%b rd_data=%h err_cnt=%0d want all 0",
               trans_in_ready, busy, eob_pulse, rd_data_valid, awvalid, wvalid, bready, arvalid, rready, rd_data, err_cnt);
    end
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (trans_in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%b busy=%b want ready=1 busy=0", trans_in_ready, busy);
    end
  endtask

  task automatic test_write_zero_wait();
    int n0_aw = n_aw, n0_w = n_w, n0_b = n_b, busy_cy = 0, rdy_lo = 0, n = 0;
    bit ok;
    aw_dly = 1; w_dly = 1; b_wait = 0;
    push(mk(8'h01, 32'h10, 32'hDEADBEEF, 8'h0F), ok);
    while ((busy || !trans_in_ready) && n < 50) begin
      busy_cy += int'(busy);
      rdy_lo += int'(!trans_in_ready);
      @(negedge clk);
      n++;
    end
    model_write(32'h10, 32'hDEADBEEF, 8'h0F);
    checks++;
    if (!ok || busy_cy != 3 || rdy_lo != 3) begin
      errors++;
      $display("FAIL write_latency got busy_cycles=%0d ready_low=%0d accepted=%b want 3 3 1", busy_cy, rdy_lo, ok);
    end
    checks++;
    if (lg_awaddr !== 32'h10 || lg_wdata !== 32'hDEADBEEF || lg_wstrb !== 4'hF || prot_bad != 0) begin
      errors++;
      $display("FAIL write_payload got addr=%h data=%h strb=%h prot_bad=%0d want 00000010 deadbeef f 0", lg_awaddr, lg_wdata, lg_wstrb, prot_bad);
    end
    checks++;
    if (n_aw - n0_aw != 1 || n_w - n0_w != 1 || n_b - n0_b != 1) begin
      errors++;
      $display("FAIL write_counts got aw=%0d w=%0d b=%0d want 1 1 1", n_aw - n0_aw, n_w - n0_w, n_b - n0_b);
    end
  endtask

  task automatic test_write_delayed();
    int h_aw = aw_hi, h_w = w_hi, n0_b = n_b;
    bit ok;
    aw_dly = 4; w_dly = 1;
    do_write(8'h80, 32'h14, 32'hCAFEF00D, 8'hF5, ok);
    checks++;
    if (!ok || aw_hi - h_aw != 4 || w_hi - h_w != 1 || n_b - n0_b != 1) begin
      errors++;
      $display("FAIL write_delayed got awvalid_cycles=%0d wvalid_cycles=%0d b=%0d ok=%b want 4 1 1 1", aw_hi - h_aw, w_hi - h_w, n_b - n0_b, ok);
    end
    checks++;
    if (lg_awaddr !== 32'h14 || lg_wdata !== 32'hCAFEF00D || lg_wstrb !== 4'h5) begin
      errors++;
      $display("FAIL write_delayed_payload got addr=%h data=%h strb=%h want 00000014 cafef00d 5", lg_awaddr, lg_wdata, lg_wstrb);
    end
    aw_dly = 1;
  endtask

  task automatic test_read();
    logic [31:0] exp;
    int bad = 0;
    bit ok, ok2;
    do_write(8'h01, 32'h20, 32'h12345678, 8'h0F, ok);
    exp = model_read(32'h20);
    push(mk(8'h00, 32'h20, 32'h0, 8'h00), ok);
    wait_rd(ok2);
    checks++;
    if (!ok || !ok2 || rd_data !== exp || lg_araddr !== 32'h20) begin
      errors++;
      $display("FAIL read_data got rd_data=%h araddr=%h ok=%b%b want %h 00000020 11", rd_data, lg_araddr, ok, ok2, exp);
    end
    for (int i = 0; i < 5; i++) begin
      if (rd_data !== exp || rd_data_valid !== 1'b1 || trans_in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL read_hold got unstable_cycles=%0d want 0", bad);
    end
    rd_data_ready = 1'b1;
    @(negedge clk);
    rd_data_ready = 1'b0;
    checks++;
    if (rd_data_valid !== 1'b0 || busy !== 1'b0 || trans_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_release got rdv=%b busy=%b ready=%b want 0 0 1", rd_data_valid, busy, trans_in_ready);
    end
  endtask

  task automatic test_eob();
    int n0_aw = n_aw, n0_ar = n_ar, e = 0, b = 0, act = 0;
    logic first;
    bit ok;
    push(80'h0, ok);
    first = eob_pulse;
    for (int i = 0; i < 4; i++) begin
      e += int'(eob_pulse);
      b += int'(busy);
      act += int'(awvalid | wvalid | arvalid);
      @(negedge clk);
    end
    checks++;
    if (!ok || first !== 1'b1 || e != 1) begin
      errors++;
      $display("FAIL eob_pulse got first=%b high_cycles=%0d want 1 1", first, e);
    end
    checks++;
    if (b != 0 || act != 0 || n_aw != n0_aw || n_ar != n0_ar) begin
      errors++;
      $display("FAIL eob_quiet got busy_cycles=%0d axi_cycles=%0d aw=%0d ar=%0d want 0 0 0 0", b, act, n_aw - n0_aw, n_ar - n0_ar);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a, d, exp;
      logic [7:0]  s, dir;
      int n0, hold;
      bit ok, ok2;
      aw_dly = $urandom_range(1, 3); w_dly = $urandom_range(1, 3); ar_dly = $urandom_range(1, 3);
      b_wait = $urandom_range(0, 2); r_wait = $urandom_range(0, 2);
      a = 32'($urandom_range(1, 6)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        dir = 8'($urandom_range(1, 255));
        d = $urandom;
        s = 8'($urandom);
        n0 = n_aw;
        do_write(dir, a, d, s, ok);
        checks++;
        if (!ok || n_aw - n0 != 1 || lg_awaddr !== a || lg_wdata !== d || lg_wstrb !== s[3:0]) begin
          errors++;
          $display("FAIL rand_write[%0d] got addr=%h data=%h strb=%h n=%0d ok=%b want %h %h %h 1 1", k, lg_awaddr, lg_wdata, lg_wstrb, n_aw - n0, ok, a, d, s[3:0]);
        end
      end else begin
        exp = model_read(a);
        hold = $urandom_range(0, 3);
        push(mk(8'h00, a, $urandom, 8'($urandom)), ok);
        wait_rd(ok2);
        repeat (hold) @(negedge clk);
        checks++;
        if (!ok || !ok2 || rd_data !== exp || lg_araddr !== a) begin
          errors++;
          $display("FAIL rand_read[%0d] got rd_data=%h araddr=%h ok=%b%b want %h %h 11", k, rd_data, lg_araddr, ok, ok2, exp, a);
        end
        rd_data_ready = 1'b1;
        @(negedge clk);
        rd_data_ready = 1'b0;
        wait_idle(ok);
      end
    end
    aw_dly = 1; w_dly = 1; ar_dly = 1; b_wait = 0; r_wait = 0;
  endtask

  task automatic test_resp_err();
    int exp_cnt;
    logic exp_flag;
    logic [31:0] exp;
    bit ok, ok2;
    int n0_b = n_b;
    bresp_val = 2'b10;
    for (int i = 0; i < 3; i++) do_write(8'h01, 32'h40 + 32'(4 * i), 32'($urandom), 8'h0F, ok);
    bresp_val = 2'b00;
`ifdef MM_RESP_CHK_EN
    exp_cnt = 3; exp_flag = 1'b1;
`else
    exp_cnt = 0; exp_flag = 1'b0;
`endif
    checks++;
    if (err_flag !== exp_flag || err_cnt !== 16'(exp_cnt) || n_b - n0_b != 3) begin
      errors++;
      $display("FAIL resp_err_write got flag=%b cnt=%0d b=%0d want %b %0d 3", err_flag, err_cnt, n_b - n0_b, exp_flag, exp_cnt);
    end
    exp = model_read(32'h44);
    rresp_val = 2'b11;
    push(mk(8'h00, 32'h44, 32'h0, 8'h00), ok);
    wait_rd(ok2);
    rresp_val = 2'b00;
    checks++;
    if (!ok2 || rd_data !== exp) begin
      errors++;
      $display("FAIL resp_err_read_data got rd_data=%h want %h", rd_data, exp);
    end
    rd_data_ready = 1'b1;
    @(negedge clk);
    rd_data_ready = 1'b0;
    wait_idle(ok);
`ifdef MM_RESP_CHK_EN
    exp_cnt = 4;
`endif
    checks++;
    if (err_flag !== exp_flag || err_cnt !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL resp_err_read got flag=%b cnt=%0d want %b %0d", err_flag, err_cnt, exp_flag, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n0_b = n_b, n0_aw;
    bit ok;
    aw_dly = 30; w_dly = 30;
    push(mk(8'h01, 32'h50, 32'h55AA55AA, 8'h0F), ok);
    @(negedge clk);
    checks++;
    if (awvalid !== 1'b1 || wvalid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre got awvalid=%b wvalid=%b want 1 1", awvalid, wvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || busy !== 1'b0 || trans_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async got awvalid=%b wvalid=%b busy=%b ready=%b want 0 0 0 0", awvalid, wvalid, busy, trans_in_ready);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    aw_dly = 1; w_dly = 1;
    @(negedge clk);
    checks++;
    if (trans_in_ready !== 1'b1 || busy !== 1'b0 || eob_pulse !== 1'b0 || rd_data_valid !== 1'b0 ||
        err_cnt !== 16'h0 || n_b != n0_b) begin
      errors++;
      $display("FAIL reset_mid_idle got ready=%b busy=%b eob=%b rdv=%b err_cnt=%0d b=%0d want 1 0 0 0 0 0",
               trans_in_ready, busy, eob_pulse, rd_data_valid, err_cnt, n_b - n0_b);
    end
    n0_aw = n_aw;
    do_write(8'h02, 32'h54, 32'h0BADCAFE, 8'h03, ok);
    checks++;
    if (!ok || n_aw - n0_aw != 1 || lg_awaddr !== 32'h54 || lg_wdata !== 32'h0BADCAFE || lg_wstrb !== 4'h3) begin
      errors++;
      $display("FAIL reset_mid_resume got addr=%h data=%h strb=%h n=%0d want 00000054 0badcafe 3 1", lg_awaddr, lg_wdata, lg_wstrb, n_aw - n0_aw);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_delayed();
    test_read();
    test_eob();
    test_random();
    test_resp_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
